id_fetch_queue: RTL and testbench
=================================

// Module: id_fetch_queue
// PURPOSE
//  Parametrised fetch-to-decode instruction queue between IF and ID.
//  Generalises the single-entry stall capture of inst_sram_rdata into a DEPTH-entry FIFO of {pc, inst}.
//  Absorbs SRAM return data while ID is stalled or blocked by a load-use hazard, and is flushed on a taken branch.
//  Drives ID's pc/inst inputs; supplies a zero NOP bubble when empty.
// PARAMETERS
//  DEPTH    4   entry count; power of two, >= 2
//  PC_WD    32  pc width
//  INST_WD  32  instruction width
//  BYPASS   0   1: an empty queue forwards in_* to out_* in the same cycle
//  PTR_WD   $clog2(DEPTH)  derived; do not override
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous, active-high reset
//  flush      in   1            taken branch/jump from ID (br_e); discards all entries
//  in_valid   in   1            IF presents a valid {in_pc, in_inst} this cycle
//  in_pc      in   PC_WD        pc of the returned instruction
//  in_inst    in   INST_WD      inst_sram_rdata aligned to in_pc
//  in_ready   out  1            queue accepts a push this cycle
//  out_valid  out  1            out_pc/out_inst hold a real instruction
//  out_pc     out  PC_WD        head pc; 0 when !out_valid
//  out_inst   out  INST_WD      head instruction; 0 (NOP) when !out_valid
//  out_ready  in   1            ID consumes the head (stall[2]==NoStop && !stallreq)
//  count      out  PTR_WD+1     occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, count=0; so in_ready=1, out_valid=0, out_pc=0, out_inst=0 the cycle after rst.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both take effect at posedge.
//  - in_ready = (count != DEPTH) from registered state only; no combinational path from out_ready.
//  - Full + pop in the same cycle: in_ready is still 0, so no push; the slot frees next cycle.
//  - Push + pop on a non-empty, non-full queue: count unchanged, both pointers advance.
//  - out_* = storage[rd_ptr], combinational from flops; 0-latency read, 1-cycle write-to-out latency (BYPASS=0).
//  - BYPASS=1 and count==0: out_valid=in_valid, out_*=in_*. If out_ready is also high, the entry is
//    consumed and not written (count stays 0). Otherwise it is pushed normally.
//  - Pointers are PTR_WD bits and wrap from DEPTH-1 to 0. Full/empty are decided by count, not by pointer compare.
//  - flush: next state is wr_ptr=rd_ptr=0, count=0. Same-cycle push and pop are ignored.
//    out_* still shows the current head during the flush cycle; ID's own flush gating kills it.
//  - rst has priority over flush; flush has priority over push/pop.
//  - Reset mid-operation discards all entries; storage contents are don't-care but are never visible
//    (out_* is gated to 0 when empty).
//  - Storage is not reset (flop array); only pointers and count are reset.
//  - No X on outputs after reset regardless of in_* values while in_valid=0.
// STRUCTURE
//  - lib/defines.vh gains: `IFQ_DEPTH (4), `IFQ_WD (PC_WD+INST_WD = 64), `INST_NOP (32'h0).
//  - Sub-module ifq_regarray: DEPTH x (PC_WD+INST_WD) flop array with 1 write port and 1 async read port.
//  - Pointer/count control, bypass mux and output gating stay in id_fetch_queue.
// TESTING
//  - Reset: after rst for 2 cycles -> count=0, in_ready=1, out_valid=0, out_inst=0, out_pc=0.
//  - Fill: out_ready=0, push pc 0xBFC00000..0xBFC0000C -> count=4, in_ready=0; a 5th push is dropped
//    (pc 0xBFC00010 never appears).
//  - Drain with wrap: push 6 and pop 6 interleaved with DEPTH=4 -> outputs appear in pc order
//    0x..00,04,..14; count never exceeds 4.
//  - Simultaneous push/pop at count=2 -> count stays 2; head advances by one entry.
//  - Flush: with count=3, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0,
//    and the flushed-cycle pc is absent.
//  - BYPASS=1: empty queue, in_valid=1, out_ready=1, in_inst=0x3C011234 -> out_inst=0x3C011234 the same cycle, count stays 0.

Source files
------------

// File: rtl/id_fetch_queue_pkg.sv
// Package: id_fetch_queue_pkg
// Shared constants for the IF->ID fetch queue.
//   IFQ_DEPTH    default queue depth
//   IFQ_PC_WD    default pc width
//   IFQ_INST_WD  default instruction width
//   IFQ_WD       width of one stored {pc, inst} entry
//   INST_NOP     bubble instruction presented when the queue is empty
package id_fetch_queue_pkg;

  localparam int IFQ_DEPTH   = 4;
  localparam int IFQ_PC_WD   = 32;
  localparam int IFQ_INST_WD = 32;
  localparam int IFQ_WD      = IFQ_PC_WD + IFQ_INST_WD;

  localparam logic [IFQ_INST_WD-1:0] INST_NOP = 32'h0;

endpackage

// File: rtl/ifq_regarray.sv
// Module: ifq_regarray
// DEPTH x WD flop array holding the fetch queue's {pc, inst} entries.
// One synchronous write port and one asynchronous (combinational) read port.
// Contents are not reset; the owner gates the read data when no entry is valid.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write slot
//   wr_data  in   entry to store
//   rd_addr  in   read slot
//   rd_data  out  entry at rd_addr, same cycle
module ifq_regarray #(
  parameter int DEPTH   = 4,
  parameter int WD      = 64,
  parameter int ADDR_WD = 2
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_WD-1:0] wr_addr,
  input  logic [WD-1:0]      wr_data,
  input  logic [ADDR_WD-1:0] rd_addr,
  output logic [WD-1:0]      rd_data
);

  logic [WD-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/id_fetch_queue.sv
// Module: id_fetch_queue
// Fetch-to-decode instruction queue. Captures {pc, inst} returned by the
// instruction SRAM while ID is stalled, feeds ID in order, drops everything on
// a taken branch, and shows a zero NOP bubble when empty.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   flush      discard all entries (taken branch/jump)
//   in_valid   IF presents {in_pc, in_inst}
//   in_pc      pc of the returned instruction
//   in_inst    instruction aligned to in_pc
//   in_ready   a push is accepted this cycle (registered state only)
//   out_valid  out_pc/out_inst hold a real instruction
//   out_pc     head pc, 0 when !out_valid
//   out_inst   head instruction, NOP when !out_valid
//   out_ready  ID consumes the head
//   count      occupancy 0..DEPTH
module id_fetch_queue
  import id_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = IFQ_DEPTH,
  parameter int PC_WD   = IFQ_PC_WD,
  parameter int INST_WD = IFQ_INST_WD,
  parameter int BYPASS  = 0,
  localparam int PTR_WD = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [PC_WD-1:0]   in_pc,
  input  logic [INST_WD-1:0] in_inst,
  output logic               in_ready,
  output logic               out_valid,
  output logic [PC_WD-1:0]   out_pc,
  output logic [INST_WD-1:0] out_inst,
  input  logic               out_ready,
  output logic [PTR_WD:0]    count
);

  localparam int WD = PC_WD + INST_WD;
  localparam logic [PTR_WD:0] FULL_CNT = (PTR_WD+1)'(DEPTH);

  logic [PTR_WD-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_WD-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_WD:0]   count_reg, count_next;

  logic          empty;
  logic          full;
  logic          byp_active;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;
  logic [WD-1:0] head_data;

  // Full/empty come from the occupancy counter, so equal pointers are never ambiguous.
  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_CNT);

  // Depends on registered state only: no combinational path from out_ready.
  assign in_ready = !full;

  // Empty-queue forwarding of the incoming instruction (BYPASS builds only).
  assign byp_active = (BYPASS != 0) && empty && in_valid;

  assign out_valid = !empty || byp_active;

  always_comb begin
    out_pc   = '0;
    out_inst = INST_WD'(INST_NOP);
    if (!empty) begin
      {out_pc, out_inst} = head_data;
    end else if (byp_active) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // A forwarded instruction that ID takes immediately never touches storage.
  assign wr_en = push && !flush && !(byp_active && out_ready);
  assign rd_en = pop && !empty && !flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // DEPTH is a power of two, so the natural overflow wraps DEPTH-1 -> 0.
      if (wr_en) wr_ptr_next = wr_ptr_reg + PTR_WD'(1);
      if (rd_en) rd_ptr_next = rd_ptr_reg + PTR_WD'(1);
      case ({wr_en, rd_en})
        2'b10:   count_next = count_reg + (PTR_WD+1)'(1);
        2'b01:   count_next = count_reg - (PTR_WD+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign count = count_reg;

  ifq_regarray #(
    .DEPTH   (DEPTH),
    .WD      (WD),
    .ADDR_WD (PTR_WD)
  ) u_regarray (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data ({in_pc, in_inst}),
    .rd_addr (rd_ptr_reg),
    .rd_data (head_data)
  );

endmodule

// File: tb/tb_id_fetch_queue.sv
// Testbench: tb_id_fetch_queue
// Drives one stimulus stream into a BYPASS=0 and a BYPASS=1 instance and
// compares both against queue-based reference models every cycle, plus
// directed checks for fill, wrap, concurrent push/pop, flush and bypass.
module tb_id_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_ready;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_pc0, out_inst0, out_pc1, out_inst1;
  logic [2:0]  count0, count1;

  id_fetch_queue #(.DEPTH(DEPTH), .PC_WD(32), .INST_WD(32), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_pc(out_pc0), .out_inst(out_inst0),
    .out_ready(out_ready), .count(count0)
  );

  id_fetch_queue #(.DEPTH(DEPTH), .PC_WD(32), .INST_WD(32), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_pc(out_pc1), .out_inst(out_inst1),
    .out_ready(out_ready), .count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [31:0] popped0[$];
  int          max_cnt0 = 0;
  logic [31:0] obs_inst1;
  logic        obs_valid1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: check outputs mid-cycle, then advance the models.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl, input logic r);
    logic        e_valid;
    logic [63:0] e_data;
    bit          do_push;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = ins;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #3;
    // plain queue
    e_valid = (q0.size() > 0);
    e_data  = e_valid ? q0[0] : 64'h0;
    chk("cnt0",   64'(count0), 64'(q0.size()));
    chk("irdy0",  64'(in_ready0), 64'(q0.size() < DEPTH));
    chk("oval0",  64'(out_valid0), 64'(e_valid));
    chk("opc0",   64'(out_pc0), 64'(e_data[63:32]));
    chk("oinst0", 64'(out_inst0), 64'(e_data[31:0]));
    // bypass queue
    if (q1.size() > 0) begin
      e_valid = 1'b1;
      e_data  = q1[0];
    end else begin
      e_valid = v;
      e_data  = v ? {pc, ins} : 64'h0;
    end
    chk("cnt1",   64'(count1), 64'(q1.size()));
    chk("irdy1",  64'(in_ready1), 64'(q1.size() < DEPTH));
    chk("oval1",  64'(out_valid1), 64'(e_valid));
    chk("opc1",   64'(out_pc1), 64'(e_data[63:32]));
    chk("oinst1", 64'(out_inst1), 64'(e_data[31:0]));
    obs_inst1  = out_inst1;
    obs_valid1 = out_valid1;
    if (out_valid0 && ordy && !fl && !r) popped0.push_back(out_pc0);
    if (int'(count0) > max_cnt0) max_cnt0 = int'(count0);
    $display("cyc %0d v=%0d pc=%h rdy=%0d fl=%0d rst=%0d cnt0=%0d cnt1=%0d",
             cyc, v, pc, ordy, fl, r, count0, count1);
    // model update, plain queue
    if (r || fl) begin
      q0.delete();
    end else begin
      do_push = v && (q0.size() < DEPTH);
      if (q0.size() > 0 && ordy) void'(q0.pop_front());
      if (do_push) q0.push_back({pc, ins});
    end
    // model update, bypass queue
    if (r || fl) begin
      q1.delete();
    end else if (!(q1.size() == 0 && v && ordy)) begin
      do_push = v && (q1.size() < DEPTH);
      if (q1.size() > 0 && ordy) void'(q1.pop_front());
      if (do_push) q1.push_back({pc, ins});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [31:0] base;
    bit          seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_inst = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    chk("rst_cnt",  64'(count0), 64'd0);
    chk("rst_irdy", 64'(in_ready0), 64'd1);
    chk("rst_oval", 64'(out_valid0), 64'd0);
    chk("rst_inst", 64'(out_inst0), 64'd0);
    chk("rst_pc",   64'(out_pc0), 64'd0);
    cycle(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Fill: four pushes, the fifth is dropped.
    base = 32'hBFC0_0000;
    for (int i = 0; i < 5; i++)
      cycle(1'b1, base + 32'(4*i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_cnt",  64'(count0), 64'd4);
    chk("fill_irdy", 64'(in_ready0), 64'd0);
    popped0.delete();
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    foreach (popped0[i]) if (popped0[i] == 32'hBFC0_0010) seen = 1'b1;
    chk("fill_drop", 64'(seen), 64'd0);
    chk("fill_npop", 64'(popped0.size()), 64'd4);

    // Drain with wrap: 6 interleaved pushes/pops.
    popped0.delete();
    max_cnt0 = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, base + 32'(4*i), 32'h2000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("wrap_npop", 64'(popped0.size()), 64'd6);
    for (int i = 0; i < 6 && i < popped0.size(); i++)
      chk("wrap_order", 64'(popped0[i]), 64'(base + 32'(4*i)));
    chk("wrap_max", 64'(max_cnt0 <= DEPTH), 64'd1);

    // Simultaneous push/pop at count 2.
    cycle(1'b1, 32'h0000_1000, 32'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_1004, 32'hB, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_1008, 32'hC, 1'b1, 1'b0, 1'b0);
    chk("pp_cnt",  64'(count0), 64'd2);
    chk("pp_head", 64'(out_pc0), 64'h0000_1004);

    // Flush with count 3 and a same-cycle push.
    cycle(1'b1, 32'h0000_100C, 32'hD, 1'b0, 1'b0, 1'b0);
    chk("fl_pre", 64'(count0), 64'd3);
    cycle(1'b1, 32'h0000_2000, 32'hE, 1'b0, 1'b1, 1'b0);
    chk("fl_cnt",  64'(count0), 64'd0);
    chk("fl_oval", 64'(out_valid0), 64'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("fl_gone", 64'(out_pc0 == 32'h0000_2000), 64'd0);

    // Bypass: empty queue forwards and consumes in the same cycle.
    cycle(1'b1, 32'hBFC0_0040, 32'h3C01_1234, 1'b1, 1'b0, 1'b0);
    chk("byp_inst", 64'(obs_inst1), 64'h3C01_1234);
    chk("byp_oval", 64'(obs_valid1), 64'd1);
    chk("byp_cnt",  64'(count1), 64'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic against the models.
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
            1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 63) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
